// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output peripheral.
// Also used by the optional duty shadow build (PWM_DUTY_SHADOW_EN).
package pwm_pkg;

  localparam int DUTY_W = 8;
  localparam int NUM_OUT = 16;
  localparam logic [DUTY_W-1:0] PWM_MAX_CNT = 8'd254;

  typedef logic [NUM_OUT-1:0] pin_vec_t;

  // Prescaler counter width, never narrower than one bit.
  function automatic int pre_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Register-side bundle between the SPI register block (master) and the
// PWM output peripheral (slave).
interface pwm_peripheral_if;
  import pwm_pkg::*;

  logic [7:0]        en_reg_out_7_0;
  logic [7:0]        en_reg_out_15_8;
  logic [7:0]        en_reg_pwm_7_0;
  logic [7:0]        en_reg_pwm_15_8;
  logic [DUTY_W-1:0] pwm_duty_cycle;
  pin_vec_t          out;
  logic              period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    output out, period_start
  );

endinterface

// File: rtl/pwm_timebase.sv
// Prescaler and 0..254 PWM count. wrap_o (end of period) is only exported
// when PWM_DUTY_SHADOW_EN is defined, since only the shadow register uses it.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 10
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PWM_DUTY_SHADOW_EN
  output logic              wrap_o,
`endif
  output logic [DUTY_W-1:0] pwm_cnt_o,
  output logic              period_start_o
);

  localparam int PRE_W = pre_width(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic              period_start_q, period_start_d;
  logic              tick;
  logic              wrap;

  always_comb begin
    tick = (pre_cnt_q == PRE_LAST);
    wrap = tick && (pwm_cnt_q == PWM_MAX_CNT);
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d = pwm_cnt_q;
    if (wrap) begin
      pwm_cnt_d = '0;
    end else if (tick) begin
      pwm_cnt_d = pwm_cnt_q + DUTY_W'(1);
    end
    // Registered, so the pulse lines up with the first out cycle of count 0.
    period_start_d = (pwm_cnt_q == '0) && (pre_cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  assign wrap_o = wrap;
`endif
  assign pwm_cnt_o      = pwm_cnt_q;
  assign period_start_o = period_start_q;

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pins low, static high, or from one shared 8-bit PWM waveform.
// Define PWM_DUTY_SHADOW_EN to latch the duty only at period boundaries.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_peripheral_if.slave bus
);

  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] duty_active;
  logic              pwm_level;
  pin_vec_t          en_out, en_pwm;
  pin_vec_t          out_q, out_d;

`ifdef PWM_DUTY_SHADOW_EN
  logic period_wrap;
`endif

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef PWM_DUTY_SHADOW_EN
    .wrap_o         (period_wrap),
`endif
    .pwm_cnt_o      (pwm_cnt),
    .period_start_o (bus.period_start)
  );

`ifdef PWM_DUTY_SHADOW_EN
  logic [DUTY_W-1:0] duty_q;

  // Loading on the 254->0 wrap keeps the running pulse intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else if (period_wrap) begin
      duty_q <= bus.pwm_duty_cycle;
    end
  end

  assign duty_active = duty_q;
`else
  assign duty_active = bus.pwm_duty_cycle;
`endif

  always_comb begin
    en_out    = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    en_pwm    = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    // pwm_cnt never reaches 255, so duty 0xFF is a solid high.
    pwm_level = (pwm_cnt < duty_active);
    out_d     = en_out & (~en_pwm | {NUM_OUT{pwm_level}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral (PRESCALE = 2), reference model
// derived from elapsed clocks since reset release. Honours PWM_DUTY_SHADOW_EN.
module tb_pwm_peripheral;
  import pwm_pkg::*;

  localparam int PRESCALE    = 2;
  localparam int PERIOD_CLKS = 255 * PRESCALE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pwm_peripheral_if bus ();

  pwm_peripheral #(
    .PRESCALE (PRESCALE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position in the period is just elapsed clocks mod period.
  int unsigned n_edge;
  int          m_pos, m_cnt, m_duty, shadow_duty;
  logic [15:0] m_en_o, m_en_p;
  logic [15:0] exp_out;
  logic        exp_ps;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edge      = 0;
      exp_out     = '0;
      exp_ps      = 1'b0;
      shadow_duty = 0;
    end else begin
      m_pos  = int'(n_edge % PERIOD_CLKS);
      m_cnt  = m_pos / PRESCALE;
`ifdef PWM_DUTY_SHADOW_EN
      m_duty = shadow_duty;
`else
      m_duty = int'(bus.pwm_duty_cycle);
`endif
      m_en_o = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
      m_en_p = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
      for (int i = 0; i < 16; i++)
        exp_out[i] = m_en_o[i] && (!m_en_p[i] || (m_cnt < m_duty));
      exp_ps = (m_pos == 0);
      if (m_pos == PERIOD_CLKS - 1) shadow_duty = int'(bus.pwm_duty_cycle);
      n_edge++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("out", 32'(bus.out), 32'(exp_out));
      check("pstart", 32'(bus.period_start), 32'(exp_ps));
    end
  end

  task automatic set_regs(input logic [15:0] en_o, input logic [15:0] en_p, input logic [7:0] duty);
    bus.en_reg_out_7_0  = en_o[7:0];
    bus.en_reg_out_15_8 = en_o[15:8];
    bus.en_reg_pwm_7_0  = en_p[7:0];
    bus.en_reg_pwm_15_8 = en_p[15:8];
    bus.pwm_duty_cycle  = duty;
  endtask

  // Samples at negedges until a period_start is seen; that cycle is not counted.
  task automatic count_until_ps(output int highs, output int len);
    highs = 0;
    len   = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (bus.period_start) break;
      highs += int'(bus.out[0]);
      len++;
    end
    check("ps_seen", 32'(bus.period_start), 32'd1);
  endtask

  // Syncs to a period_start, then measures out[0] over one full period.
  task automatic measure_period(output int highs, output int len);
    int h, l, h0;
    count_until_ps(h, l);
    h0 = int'(bus.out[0]);
    count_until_ps(h, l);
    highs = h0 + h;
    len   = l + 1;
  endtask

  int hi, ln, h0;
  int exp_hi;

  initial begin
    set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_out", 32'(bus.out), 32'h0);
      check("rst_ps", 32'(bus.period_start), 32'h0);
    end
    set_regs(16'h0000, 16'h0000, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_out", 32'(bus.out), 32'h0);

    bus.en_reg_out_7_0 = 8'hFF;
    @(negedge clk);
    check("static_lo", 32'(bus.out), 32'h00FF);
    bus.en_reg_out_15_8 = 8'hA5;
    @(negedge clk);
    check("static_hi", 32'(bus.out), 32'hA5FF);

    set_regs(16'h0001, 16'h0001, 8'h80);
    measure_period(hi, ln);
    check("duty50_high", 32'(hi), 32'd256);
    check("duty50_len", 32'(ln), 32'd510);

    bus.pwm_duty_cycle = 8'h00;
    measure_period(hi, ln);
    check("duty00_p0", 32'(hi), 32'd0);
    repeat (2) begin
      count_until_ps(hi, ln);
      check("duty00_pn", 32'(hi + int'(bus.out[0])), 32'd0);
    end
    bus.pwm_duty_cycle = 8'hFF;
    measure_period(hi, ln);
    check("dutyFF_p0", 32'(hi), 32'd510);
    repeat (2) begin
      h0 = int'(bus.out[0]);
      count_until_ps(hi, ln);
      check("dutyFF_pn", 32'(h0 + hi), 32'd510);
    end
    @(negedge clk);
    set_regs(16'h0000, 16'hFFFF, 8'hFF);
    repeat (3) @(negedge clk);
    check("pwm_no_en", 32'(bus.out), 32'h0);

    // Duty change from 0x40 to 0xC0 while pwm_cnt is 100.
    set_regs(16'h0001, 16'h0001, 8'h40);
    measure_period(hi, ln);
    check("d40_high", 32'(hi), 32'd128);
    repeat (100 * PRESCALE) @(negedge clk);
    bus.pwm_duty_cycle = 8'hC0;
    repeat (2) @(negedge clk);
`ifdef PWM_DUTY_SHADOW_EN
    check("shadow_hold", 32'(bus.out[0]), 32'd0);
    exp_hi = 0;
`else
    check("direct_rise", 32'(bus.out[0]), 32'd1);
    exp_hi = 181;
`endif
    count_until_ps(hi, ln);
    check("rest_of_period", 32'(hi), 32'(exp_hi));
    h0 = int'(bus.out[0]);
    count_until_ps(hi, ln);
    check("dC0_high", 32'(h0 + hi), 32'd384);

    // Mid-period reset at pwm_cnt 150 (out[0] is high there).
    repeat (150 * PRESCALE) @(negedge clk);
    check("pre_rst_out0", 32'(bus.out[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(bus.out), 32'h0);
    check("async_rst_ps", 32'(bus.period_start), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ps", 32'(bus.period_start), 32'd1);
    h0 = int'(bus.out[0]);
    count_until_ps(hi, ln);
`ifdef PWM_DUTY_SHADOW_EN
    exp_hi = 0;
`else
    exp_hi = 384;
`endif
    check("rel_high", 32'(h0 + hi), 32'(exp_hi));
    check("rel_len", 32'(ln + 1), 32'd510);

    // Random register traffic, checked every cycle by the model.
    for (int k = 0; k < 20; k++) begin
      set_regs(16'($urandom), 16'($urandom), 8'($urandom));
      if (k % 5 == 0) bus.pwm_duty_cycle = (k % 10 == 0) ? 8'h00 : 8'hFF;
      repeat ($urandom_range(400, 1)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
